// File: rtl/mvu_pkg.sv
// Shared widths and sequencer state encoding for the MVU address generation unit.
package mvu_pkg;

  localparam int BWBANKA = 9;
  localparam int BDBANKA = 15;
  localparam int BCNTDWN = 29;
  localparam int BSTRIDE = 15;
  localparam int BLENGTH = 15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } agu_state_e;

endpackage

// File: rtl/agu_nest3.sv
// Three-level nested-loop address generator; config is captured on load.
module agu_nest3
  import mvu_pkg::*;
#(
  parameter int AW = BDBANKA
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_i,
  input  logic [AW-1:0]      base_i,
  input  logic [BSTRIDE-1:0] stride0_i,
  input  logic [BSTRIDE-1:0] stride1_i,
  input  logic [BSTRIDE-1:0] stride2_i,
  input  logic [BLENGTH-1:0] length0_i,
  input  logic [BLENGTH-1:0] length1_i,
  input  logic [BLENGTH-1:0] length2_i,
  input  logic               step_i,
  output logic [AW-1:0]      addr_o
);

  logic [AW-1:0]      base_q, addr_q, addr_d;
  logic [BSTRIDE-1:0] s0_q, s1_q, s2_q;
  logic [BLENGTH-1:0] l0_q, l1_q, l2_q;
  logic [BLENGTH-1:0] c0_q, c0_d, c1_q, c1_d, c2_q, c2_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q <= '0;
      s0_q   <= '0;
      s1_q   <= '0;
      s2_q   <= '0;
      l0_q   <= '0;
      l1_q   <= '0;
      l2_q   <= '0;
    end else if (load_i) begin
      base_q <= base_i;
      s0_q   <= stride0_i;
      s1_q   <= stride1_i;
      s2_q   <= stride2_i;
      l0_q   <= length0_i;
      l1_q   <= length1_i;
      l2_q   <= length2_i;
    end
  end

  // Strides wider than the address simply wrap modulo 2^AW.
  always_comb begin
    addr_d = addr_q;
    c0_d   = c0_q;
    c1_d   = c1_q;
    c2_d   = c2_q;
    if (load_i) begin
      addr_d = base_i;
      c0_d   = '0;
      c1_d   = '0;
      c2_d   = '0;
    end else if (step_i) begin
      if (c0_q < l0_q) begin
        c0_d   = c0_q + BLENGTH'(1);
        addr_d = addr_q + AW'(s0_q);
      end else if (c1_q < l1_q) begin
        c0_d   = '0;
        c1_d   = c1_q + BLENGTH'(1);
        addr_d = addr_q + AW'(s1_q);
      end else if (c2_q < l2_q) begin
        c0_d   = '0;
        c1_d   = '0;
        c2_d   = c2_q + BLENGTH'(1);
        addr_d = addr_q + AW'(s2_q);
      end else begin
        c0_d   = '0;
        c1_d   = '0;
        c2_d   = '0;
        addr_d = base_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      c0_q   <= '0;
      c1_q   <= '0;
      c2_q   <= '0;
    end else begin
      addr_q <= addr_d;
      c0_q   <= c0_d;
      c1_q   <= c1_d;
      c2_q   <= c2_d;
    end
  end

  assign addr_o = addr_q;

endmodule

// File: rtl/mvu_agu.sv
// Per-MVU job sequencer: walks weight/input read addresses for a job and
// steps output write addresses on quantizer requests.
module mvu_agu
  import mvu_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [BCNTDWN-1:0] countdown,
  input  logic [BWBANKA-1:0] wbaseaddr,
  input  logic [BDBANKA-1:0] ibaseaddr,
  input  logic [BDBANKA-1:0] obaseaddr,
  input  logic [BSTRIDE-1:0] wstride_0,
  input  logic [BSTRIDE-1:0] wstride_1,
  input  logic [BSTRIDE-1:0] wstride_2,
  input  logic [BSTRIDE-1:0] istride_0,
  input  logic [BSTRIDE-1:0] istride_1,
  input  logic [BSTRIDE-1:0] istride_2,
  input  logic [BSTRIDE-1:0] ostride_0,
  input  logic [BSTRIDE-1:0] ostride_1,
  input  logic [BSTRIDE-1:0] ostride_2,
  input  logic [BLENGTH-1:0] wlength_0,
  input  logic [BLENGTH-1:0] wlength_1,
  input  logic [BLENGTH-1:0] wlength_2,
  input  logic [BLENGTH-1:0] ilength_0,
  input  logic [BLENGTH-1:0] ilength_1,
  input  logic [BLENGTH-1:0] ilength_2,
  input  logic [BLENGTH-1:0] olength_0,
  input  logic [BLENGTH-1:0] olength_1,
  input  logic [BLENGTH-1:0] olength_2,
  input  logic               o_step,
  output logic [BWBANKA-1:0] rdw_addr,
  output logic               rdd_en,
  input  logic               rdd_grnt,
  output logic [BDBANKA-1:0] rdd_addr,
  output logic               wrd_en,
  input  logic               wrd_grnt,
  output logic [BDBANKA-1:0] wrd_addr,
  output logic               busy,
  output logic               done,
  output logic               err
);

  agu_state_e         state_q, state_d;
  logic [BCNTDWN-1:0] cnt_q, cntdwn_q;
  logic               load, beat, last_beat, o_adv;
  logic               wrd_en_q, wrd_en_d, err_q, err_d;

  // start is only honoured from IDLE; it also re-bases the output path.
  assign load      = start && (state_q == ST_IDLE);
  assign beat      = (state_q == ST_RUN) && rdd_grnt;
  assign last_beat = (cnt_q + BCNTDWN'(1)) == cntdwn_q;
  assign o_adv     = wrd_en_q && wrd_grnt && !load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = (countdown != '0) ? ST_RUN : ST_DONE;
      ST_RUN:  if (beat && last_beat) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy   = (state_q == ST_RUN);
    rdd_en = (state_q == ST_RUN);
    done   = (state_q == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      cntdwn_q <= '0;
    end else if (load) begin
      cnt_q    <= '0;
      cntdwn_q <= countdown;
    end else if (beat) begin
      cnt_q    <= cnt_q + BCNTDWN'(1);
    end
  end

  always_comb begin
    wrd_en_d = wrd_en_q;
    err_d    = err_q;
    if (load) begin
      wrd_en_d = 1'b0;
      err_d    = 1'b0;
    end else if (wrd_en_q) begin
      if (wrd_grnt) wrd_en_d = o_step;
      else if (o_step) err_d = 1'b1;
    end else if (o_step) begin
      wrd_en_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrd_en_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      wrd_en_q <= wrd_en_d;
      err_q    <= err_d;
    end
  end

  assign wrd_en = wrd_en_q;
  assign err    = err_q;

  agu_nest3 #(.AW(BWBANKA)) u_wgen (
    .clk(clk), .rst_n(rst_n), .load_i(load), .base_i(wbaseaddr),
    .stride0_i(wstride_0), .stride1_i(wstride_1), .stride2_i(wstride_2),
    .length0_i(wlength_0), .length1_i(wlength_1), .length2_i(wlength_2),
    .step_i(beat), .addr_o(rdw_addr)
  );

  agu_nest3 #(.AW(BDBANKA)) u_igen (
    .clk(clk), .rst_n(rst_n), .load_i(load), .base_i(ibaseaddr),
    .stride0_i(istride_0), .stride1_i(istride_1), .stride2_i(istride_2),
    .length0_i(ilength_0), .length1_i(ilength_1), .length2_i(ilength_2),
    .step_i(beat), .addr_o(rdd_addr)
  );

  agu_nest3 #(.AW(BDBANKA)) u_ogen (
    .clk(clk), .rst_n(rst_n), .load_i(load), .base_i(obaseaddr),
    .stride0_i(ostride_0), .stride1_i(ostride_1), .stride2_i(ostride_2),
    .length0_i(olength_0), .length1_i(olength_1), .length2_i(olength_2),
    .step_i(o_adv), .addr_o(wrd_addr)
  );

endmodule

// File: tb/tb_mvu_agu.sv
// Directed bench for mvu_agu: read walks, stalls, zero jobs, writes, wrap, reset.
module tb_mvu_agu;
  import mvu_pkg::*;

  logic               clk = 1'b0;
  logic               rst_n, start, o_step, rdd_grnt, wrd_grnt;
  logic [BCNTDWN-1:0] countdown;
  logic [BWBANKA-1:0] wbaseaddr;
  logic [BDBANKA-1:0] ibaseaddr, obaseaddr;
  logic [BSTRIDE-1:0] wstride_0, wstride_1, wstride_2;
  logic [BSTRIDE-1:0] istride_0, istride_1, istride_2;
  logic [BSTRIDE-1:0] ostride_0, ostride_1, ostride_2;
  logic [BLENGTH-1:0] wlength_0, wlength_1, wlength_2;
  logic [BLENGTH-1:0] ilength_0, ilength_1, ilength_2;
  logic [BLENGTH-1:0] olength_0, olength_1, olength_2;
  logic [BWBANKA-1:0] rdw_addr;
  logic [BDBANKA-1:0] rdd_addr, wrd_addr;
  logic               rdd_en, wrd_en, busy, done, err;

  int nvec = 0;
  int nerr = 0;
  int exp_q[$];
  bit gmask_q[$];

  always #5 clk = ~clk;

  mvu_agu dut (
    .clk(clk), .rst_n(rst_n), .start(start), .countdown(countdown),
    .wbaseaddr(wbaseaddr), .ibaseaddr(ibaseaddr), .obaseaddr(obaseaddr),
    .wstride_0(wstride_0), .wstride_1(wstride_1), .wstride_2(wstride_2),
    .istride_0(istride_0), .istride_1(istride_1), .istride_2(istride_2),
    .ostride_0(ostride_0), .ostride_1(ostride_1), .ostride_2(ostride_2),
    .wlength_0(wlength_0), .wlength_1(wlength_1), .wlength_2(wlength_2),
    .ilength_0(ilength_0), .ilength_1(ilength_1), .ilength_2(ilength_2),
    .olength_0(olength_0), .olength_1(olength_1), .olength_2(olength_2),
    .o_step(o_step), .rdw_addr(rdw_addr), .rdd_en(rdd_en), .rdd_grnt(rdd_grnt),
    .rdd_addr(rdd_addr), .wrd_en(wrd_en), .wrd_grnt(wrd_grnt), .wrd_addr(wrd_addr),
    .busy(busy), .done(done), .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_clear();
    countdown = '0; wbaseaddr = '0; ibaseaddr = '0; obaseaddr = '0;
    wstride_0 = '0; wstride_1 = '0; wstride_2 = '0;
    istride_0 = '0; istride_1 = '0; istride_2 = '0;
    ostride_0 = '0; ostride_1 = '0; ostride_2 = '0;
    wlength_0 = '0; wlength_1 = '0; wlength_2 = '0;
    ilength_0 = '0; ilength_1 = '0; ilength_2 = '0;
    olength_0 = '0; olength_1 = '0; olength_2 = '0;
  endtask

  task automatic cfg_nest();
    cfg_clear();
    wbaseaddr = 5; countdown = 8;
    wlength_0 = 2; wlength_1 = 1; wlength_2 = 0;
    wstride_0 = 1; wstride_1 = 10; wstride_2 = 100;
  endtask

  task automatic start_job();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // One entry of exp_q/gmask_q per RUN cycle; the job must end on the last one.
  task automatic run_seq(input string tag, input bit use_i, input int start_at);
    for (int k = 0; k < exp_q.size(); k++) begin
      rdd_grnt = gmask_q[k];
      start    = (k == start_at);
      if (k == start_at) begin
        wbaseaddr = 200; countdown = 3;
      end
      chk({tag, "_busy"}, busy, 1);
      chk({tag, "_rdd_en"}, rdd_en, 1);
      chk({tag, "_addr"}, use_i ? 32'(rdd_addr) : 32'(rdw_addr), exp_q[k]);
      tick();
    end
    start    = 1'b0;
    rdd_grnt = 1'b1;
    chk({tag, "_done"}, done, 1);
    chk({tag, "_busy_end"}, busy, 0);
    chk({tag, "_rdd_en_end"}, rdd_en, 0);
    tick();
    chk({tag, "_done_pulse"}, done, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; o_step = 1'b0; rdd_grnt = 1'b1; wrd_grnt = 1'b0;
    cfg_clear();
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rdd_en", rdd_en, 0);
    chk("rst_wrd_en", wrd_en, 0);
    chk("rst_err", err, 0);
    chk("rst_rdw", rdw_addr, 0);
    chk("rst_rdd", rdd_addr, 0);
    chk("rst_wrd", wrd_addr, 0);
    rst_n = 1'b1;
    tick();

    // Nested walk, grant always high
    cfg_nest();
    exp_q   = '{5, 6, 7, 17, 18, 19, 5, 6};
    gmask_q = '{1, 1, 1, 1, 1, 1, 1, 1};
    start_job();
    run_seq("nest", 1'b0, -1);

    // Grant low on RUN cycles 3..5
    cfg_nest();
    exp_q   = '{5, 6, 7, 7, 7, 7, 17, 18, 19, 5, 6};
    gmask_q = '{1, 1, 0, 0, 0, 1, 1, 1, 1, 1, 1};
    start_job();
    run_seq("stall", 1'b0, -1);

    // Zero-length job
    cfg_clear();
    start_job();
    chk("zero_done", done, 1);
    chk("zero_rdd_en", rdd_en, 0);
    chk("zero_busy", busy, 0);
    tick();
    chk("zero_done_pulse", done, 0);
    chk("zero_rdd_en2", rdd_en, 0);

    // Input-address wrap modulo 2^15
    cfg_clear();
    ibaseaddr = 15'h7FFE; istride_0 = 3; ilength_0 = 3; countdown = 4;
    exp_q   = '{32'h7FFE, 1, 4, 7};
    gmask_q = '{1, 1, 1, 1};
    start_job();
    run_seq("wrap", 1'b1, -1);

    // Output writes
    cfg_clear();
    obaseaddr = 100; olength_0 = 1; olength_1 = 1; ostride_0 = 4; ostride_1 = 50;
    start_job();
    tick();
    wrd_grnt = 1'b1;
    exp_q = '{100, 104, 154};
    for (int k = 0; k < 3; k++) begin
      o_step = 1'b1;
      tick();
      o_step = 1'b0;
      chk("wr_en", wrd_en, 1);
      chk("wr_addr", wrd_addr, exp_q[k]);
      tick();
      chk("wr_drop", wrd_en, 0);
    end
    wrd_grnt = 1'b0;
    o_step   = 1'b1;
    tick();
    chk("ovf_en", wrd_en, 1);
    chk("ovf_err0", err, 0);
    tick();
    o_step = 1'b0;
    chk("ovf_err", err, 1);
    chk("ovf_addr", wrd_addr, 158);
    wrd_grnt = 1'b1;
    tick();
    chk("ovf_dropped", wrd_en, 0);
    chk("ovf_sticky", err, 1);
    wrd_grnt = 1'b0;
    start_job();
    chk("ovf_clear", err, 0);
    chk("rebase", wrd_addr, 100);
    tick();

    // Back-to-back writes
    wrd_grnt = 1'b1;
    o_step   = 1'b1;
    tick();
    chk("b2b_addr0", wrd_addr, 100);
    tick();
    o_step = 1'b0;
    chk("b2b_en", wrd_en, 1);
    chk("b2b_addr1", wrd_addr, 104);
    tick();
    chk("b2b_drop", wrd_en, 0);
    wrd_grnt = 1'b0;

    // Mid-job reset at beat 4
    cfg_nest();
    start_job();
    tick(); tick(); tick();
    chk("mrst_pre", rdw_addr, 17);
    rst_n = 1'b0;
    #1;
    chk("mrst_rdw", rdw_addr, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_rdd_en", rdd_en, 0);
    chk("mrst_done", done, 0);
    tick();
    chk("mrst_done_hold", done, 0);
    rst_n = 1'b1;
    tick();
    chk("mrst_done_after", done, 0);
    chk("mrst_busy_after", busy, 0);

    // start during RUN is ignored
    cfg_nest();
    exp_q   = '{5, 6, 7, 17, 18, 19, 5, 6};
    gmask_q = '{1, 1, 1, 1, 1, 1, 1, 1};
    start_job();
    run_seq("ign", 1'b0, 2);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/mvu_agu.md
Name: mvu_agu

Overview:
Per-MVU address generation unit and job sequencer that drives one MVU's weight-read, data-read and data-write address ports. It sits directly upstream of each MVU core in mvutop and replaces the tied-off rdw_addr/rdd_*/wrd_* nets. One instance serves one MVU; mvutop instantiates NMVU of them and slices the per-MVU config buses. Each job runs for `countdown` read beats, walking three-level nested loops over weights and inputs; output writes are stepped by the quantizer.

Parameters:
BWBANKA, 9, weight bank address width
BDBANKA, 15, data bank address width
BCNTDWN, 29, countdown width
BSTRIDE, 15, stride width
BLENGTH, 15, length width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  job start pulse; latches all config
countdown  in  BCNTDWN  number of read beats in the job
wbaseaddr  in  BWBANKA  weight base address
ibaseaddr / obaseaddr  in  BDBANKA  input / output base address
wstride_0..2  in  BSTRIDE  weight jump on level-0/1/2 advance
istride_0..2 / ostride_0..2  in  BSTRIDE  input / output jumps, same rule
wlength_0..2 / ilength_0..2 / olength_0..2  in  BLENGTH  iterations minus 1 per level
o_step  in  1  one output word is ready to write
rdw_addr  out  BWBANKA  weight read address
rdd_en  out  1  data read request
rdd_grnt  in  1  data read grant
rdd_addr  out  BDBANKA  data read address
wrd_en  out  1  data write request
wrd_grnt  in  1  data write grant
wrd_addr  out  BDBANKA  data write address
busy  out  1  job in progress
done  out  1  one-cycle job-complete pulse
err  out  1  sticky: o_step dropped

Behaviour:
- Reset: all outputs 0; state IDLE; all counters 0; addresses 0.
- FSM IDLE -> RUN -> DONE -> IDLE.
- IDLE: start=1 latches config, loads the w/i/o generators with their bases, and zeroes the counters.
  - countdown != 0: go to RUN. countdown == 0: go to DONE, with no reads issued.
- RUN:
  - busy=1, rdd_en=1; rdw_addr and rdd_addr show the current generator addresses.
  - First beat appears the cycle after start.
  - A beat completes when rdd_grnt=1. Only then do the w and i generators advance and the beat counter increment.
  - rdd_grnt=0: everything holds.
  - The beat that makes the count equal to countdown moves the FSM to DONE; rdd_en=0 in the following cycle.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE.
- start while in RUN or DONE is ignored.
- Generator rule (w, i, o identical), counters c0/c1/c2:
  - c0 < length_0: c0++, addr += stride_0.
  - Else, if c1 < length_1: c0=0, c1++, addr += stride_1.
  - Else, if c2 < length_2: c0=c1=0, c2++, addr += stride_2.
  - Else: all counters 0, addr = base.
  - Strides are unsigned; the sum is truncated modulo 2^addr-width (weight strides use the low BWBANKA bits).
- Output path:
  - o_step with no write pending: wrd_en=1 with wrd_addr = current o address; held until wrd_grnt=1.
  - On grant: o generator advances and wrd_en drops next cycle, unless o_step is high in that same cycle, in which case the new request follows back-to-back.
  - o_step while a write is pending and not granted: the step is dropped and err is set.
  - err clears only on reset or start.
- The output path runs independently of the FSM, so writes may trail after done. start re-bases the o generator, aborts any pending write (wrd_en=0), and clears err.
- rst_n asserted mid-job: immediate return to the reset state; no done pulse.

Decomposition:
- Package mvu_pkg: width constants BWBANKA, BDBANKA, BCNTDWN, BSTRIDE, BLENGTH, and the FSM state enum.
- Sub-module agu_nest3, parameterized by address width, with ports:
  - load, base, strides, lengths
  - step (advance)
  - addr out
- Instantiated three times (w, i, o).

Test Plan:
- Nested walk with permanent grant:
  - Stimulus: wbase=5, wlength=2/1/0, wstride=1/10/100, countdown=8.
  - Response: rdw_addr = 5,6,7,17,18,19,5,6; done one cycle after the 8th beat; busy high for exactly 8 cycles.
- Grant stall:
  - Stimulus: same config as above; rdd_grnt low on cycles 3–5 of RUN.
  - Response: address holds at 7 during the stall; 11 RUN cycles total; done after the 8th granted beat.
- Zero-length job:
  - Stimulus: countdown=0.
  - Response: rdd_en never asserts; done pulses the cycle after start.
- Output writes:
  - Stimulus: obase=100, olength_0=1, ostride_0=4, ostride_1=50; o_step ×3, each granted immediately.
  - Response: wrd_addr = 100,104,154.
  - Then: o_step twice while wrd_grnt=0 → err=1 and the second step is dropped.
- Wrap-around:
  - Stimulus: ibase=0x7FFE, istride_0=3, ilength_0=3.
  - Response: rdd_addr = 0x7FFE, 0x0001, 0x0004, 0x0007.
- Mid-job reset and ignored start:
  - Stimulus: rst_n low at beat 4; then start during RUN.
  - Response: after reset, all outputs 0 with no done pulse; the start during RUN has no effect on addresses or the beat count.
